// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every domain in reset, then releases domains 0..N-1 in order,
// one step apart. Define RESET_SEQ_READY_EN to gate each step on dom_ready, with a timeout.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int STEP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_req,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int MAX_HS  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int MAX_CYC = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int DW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DOM_LAST  = DW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STEP,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [DW-1:0]          dom_q;
  logic [NUM_DOMAINS-1:0] rst_q;
  logic [NUM_DOMAINS-1:0] rst_d;
  logic                   busy_q;
  logic                   done_q;

  // Saturating count; releases are thermometer-coded so the next pattern is a left fill.
  assign cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign rst_d = (rst_q << 1) | NUM_DOMAINS'(1);

`ifdef RESET_SEQ_READY_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic seen_q;  // ready observed for the most recently released domain
  logic err_q;
  assign err = err_q;
`else
  logic unused_ready;
  assign unused_ready = ^dom_ready;
  assign err          = 1'b0;
`endif

  // NOTE: reset is sampled synchronously here, and all state uses non-blocking
  // assignments so every register sees the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      dom_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef RESET_SEQ_READY_EN
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_q <= NUM_DOMAINS'(1);
            cnt_q <= '0;
            dom_q <= '0;
`ifdef RESET_SEQ_READY_EN
            seen_q  <= 1'b0;
            state_q <= S_STEP;
`else
            if (NUM_DOMAINS == 1) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_STEP;
            end
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STEP: begin
`ifdef RESET_SEQ_READY_EN
          if (!seen_q) begin
            // Waiting for the released domain to report ready; a timeout counts as ready.
            if (dom_ready[dom_q] || cnt_q == TIMEOUT_LAST) begin
              if (!dom_ready[dom_q]) err_q <= 1'b1;
              cnt_q <= '0;
              if (dom_q == DOM_LAST) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                seen_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (cnt_q == STEP_LAST) begin
            rst_q  <= rst_d;
            dom_q  <= dom_q + 1'b1;
            cnt_q  <= '0;
            seen_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
`else
          if (cnt_q == STEP_LAST) begin
            rst_q <= rst_d;
            dom_q <= dom_q + 1'b1;
            cnt_q <= '0;
            if (dom_q + 1'b1 == DOM_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end

        S_DONE: begin
          if (soft_req) begin
            rst_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            dom_q   <= '0;
            state_q <= S_HOLD;
          end
        end

        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign rst_n_out = rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table plus random stimulus against an
// edge-count model; with RESET_SEQ_READY_EN it runs the ready/timeout sequences instead.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 4;
  localparam int S = 8;
  localparam int T = 64;

  logic         clk;
  logic         reset_n;
  logic         soft_req;
  logic [N-1:0] dom_ready;
  logic [N-1:0] rst_n_out;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  // Model state: edges since the sequence (re)started, and whether it has finished.
  int seq_e  = 0;
  bit m_done = 1'b0;

  reset_sequencer #(
    .NUM_DOMAINS   (N),
    .HOLD_CYCLES   (H),
    .STEP_CYCLES   (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .soft_req (soft_req),
    .dom_ready(dom_ready),
    .rst_n_out(rst_n_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Domains released by edge e of a sequence: domain k goes at edge H + k*S.
  function automatic int rel_count(input int e);
    int n;
    if (e < H) return 0;
    n = (e - H) / S + 1;
    return (n > N) ? N : n;
  endfunction

  task automatic step(input bit rn, input bit sr);
    logic [N-1:0] e_rst;
    reset_n  = rn;
    soft_req = sr;
    @(posedge clk);
    if (!rn)                seq_e = 0;
    else if (m_done && sr)  seq_e = 0;
    else if (seq_e < 100000) seq_e++;
    m_done = (rel_count(seq_e) == N);
    e_rst  = N'((1 << rel_count(seq_e)) - 1);
    #1;
`ifndef RESET_SEQ_READY_EN
    check($sformatf("model e=%0d {rst,busy,done,err}", seq_e),
          {rst_n_out, busy, done, err}, {e_rst, !m_done, m_done, 1'b0});
`else
    e_rst = e_rst;
`endif
  endtask

  task automatic run_until(input int e);
    for (int i = 0; i < 1000 && seq_e < e; i++) step(1'b1, 1'b0);
  endtask

  typedef struct {
    bit         rn;
    bit         sr;
    int         reps;
    logic [2:0] rst;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rn, input bit sr, input int reps,
                     input logic [2:0] rst, input bit b, input bit d);
    vec_t v;
    v.rn = rn; v.sr = sr; v.reps = reps; v.rst = rst; v.busy = b; v.done = d;
    tbl.push_back(v);
  endtask

  initial begin
    reset_n   = 1'b0;
    soft_req  = 1'b0;
    dom_ready = '0;

`ifndef RESET_SEQ_READY_EN
    // Power-up sequence: releases at edges 4, 12, 20.
    add(0, 0, 3, 3'b000, 1, 0);
    add(1, 0, 3, 3'b000, 1, 0);
    add(1, 0, 1, 3'b001, 1, 0);
    add(1, 0, 7, 3'b001, 1, 0);
    add(1, 0, 1, 3'b011, 1, 0);
    add(1, 0, 7, 3'b011, 1, 0);
    add(1, 0, 1, 3'b111, 0, 1);
    add(1, 0, 5, 3'b111, 0, 1);
    // Soft re-sequence from DONE.
    add(1, 1, 1, 3'b000, 1, 0);
    add(1, 0, 3, 3'b000, 1, 0);
    add(1, 0, 1, 3'b001, 1, 0);
    add(1, 0, 15, 3'b011, 1, 0);
    add(1, 0, 1, 3'b111, 0, 1);
    // soft_req while busy is dropped.
    add(0, 0, 1, 3'b000, 1, 0);
    add(1, 0, 7, 3'b001, 1, 0);
    add(1, 1, 1, 3'b001, 1, 0);
    add(1, 0, 11, 3'b011, 1, 0);
    add(1, 0, 1, 3'b111, 0, 1);
    add(1, 0, 3, 3'b111, 0, 1);
    // Reset mid-sequence, then full timing again.
    add(0, 0, 1, 3'b000, 1, 0);
    add(1, 0, 13, 3'b011, 1, 0);
    add(0, 0, 1, 3'b000, 1, 0);
    add(1, 0, 4, 3'b001, 1, 0);
    add(1, 0, 8, 3'b011, 1, 0);
    add(1, 0, 8, 3'b111, 0, 1);
    // soft_req held high restarts on every DONE entry.
    add(1, 1, 1, 3'b000, 1, 0);
    add(1, 1, 19, 3'b011, 1, 0);
    add(1, 1, 1, 3'b111, 0, 1);
    add(1, 1, 1, 3'b000, 1, 0);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].rn, tbl[i].sr);
      check($sformatf("vec%0d {rst,busy,done}", i), {rst_n_out, busy, done},
            {tbl[i].rst, tbl[i].busy, tbl[i].done});
    end

    // Random reset/soft_req traffic against the edge-count model.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0);
`else
    // Ready-gated stepping: dom_ready[0] seen at edge 10 moves release 1 to edge 18.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rdy reset", {rst_n_out, busy, done, err}, {3'b000, 1'b1, 1'b0, 1'b0});
    run_until(9);
    check("rdy e9", {rst_n_out, err}, {3'b001, 1'b0});
    dom_ready = 3'b001;
    run_until(12);
    check("rdy e12 held", {rst_n_out}, {3'b001});
    run_until(17);
    check("rdy e17", {rst_n_out}, {3'b001});
    run_until(18);
    check("rdy e18", {rst_n_out}, {3'b011});
    run_until(19);
    dom_ready = 3'b011;
    run_until(27);
    check("rdy e27", {rst_n_out}, {3'b011});
    run_until(28);
    check("rdy e28", {rst_n_out, busy, done}, {3'b111, 1'b1, 1'b0});
    run_until(29);
    check("rdy e29 wait", {busy, done}, {1'b1, 1'b0});
    dom_ready = 3'b111;
    run_until(30);
    check("rdy e30 done", {rst_n_out, busy, done, err}, {3'b111, 1'b0, 1'b1, 1'b0});

    // Stuck ready: timeouts set err and the sequence still completes.
    dom_ready = 3'b000;
    step(1'b0, 1'b0);
    check("to reset", {rst_n_out, busy, done, err}, {3'b000, 1'b1, 1'b0, 1'b0});
    run_until(67);
    check("to e67", {rst_n_out, err}, {3'b001, 1'b0});
    run_until(68);
    check("to e68 err", {rst_n_out, err}, {3'b001, 1'b1});
    run_until(75);
    check("to e75", {rst_n_out}, {3'b001});
    run_until(76);
    check("to e76", {rst_n_out}, {3'b011});
    run_until(148);
    check("to e148", {rst_n_out, done}, {3'b111, 1'b0});
    run_until(211);
    check("to e211", {busy, done}, {1'b1, 1'b0});
    run_until(212);
    check("to e212 done", {rst_n_out, busy, done, err}, {3'b111, 1'b0, 1'b1, 1'b1});
    step(1'b1, 1'b1);
    check("to soft keeps err", {rst_n_out, busy, done, err}, {3'b000, 1'b1, 1'b0, 1'b1});
    step(1'b0, 1'b0);
    check("to reset clears err", {err}, {1'b0});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
